memory_interface: RTL and testbench
===================================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 Parameter ACCESS_LATENCY, default 4, SHALL set the idle-wait cycles between request acceptance and the first word transfer; legal range 0..15.
REQ-002 Parameter MEM_DEPTH_LOG2, default c_ADDR_TAG_SIZE+c_ADDR_INDEX_SIZE, SHALL set the backing store depth in lines as 2**MEM_DEPTH_LOG2.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 RESET  input  1  SHALL be synchronous, active-high reset.
REQ-005 SIG_RAM_RD  input  1  SHALL be the line read request from the cache, a level held until acknowledged.
REQ-006 SIG_RAM_WR  input  1  SHALL be the line write-back request from the cache, a level held until acknowledged.
REQ-007 RAM_ADDR  input  MEM_DEPTH_LOG2  SHALL be the line address (tag and index).
REQ-008 MI_IN_DATA  input  c_RAM_DATA_SIZE  SHALL be the write-back line from the cache.
REQ-009 MI_OUT_DATA  output  c_RAM_DATA_SIZE  SHALL be the line returned to the cache.
REQ-010 MI_SIG_RAM_ACK  output  1  SHALL be a one-cycle completion pulse.
REQ-011 BUSY  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LATENCY, READ_BURST, WRITE_BURST, ACK, WAIT_RELEASE.
REQ-013 In IDLE, a rising edge with SIG_RAM_WR=1 SHALL latch RAM_ADDR, MI_IN_DATA and op=write; SIG_RAM_RD=1 alone SHALL latch RAM_ADDR and op=read.
REQ-014 With SIG_RAM_RD and SIG_RAM_WR both high in IDLE, the write SHALL win, and no read SHALL be performed for that request.
REQ-015 LATENCY SHALL last exactly ACCESS_LATENCY cycles, counted by a down-counter; ACCESS_LATENCY=0 SHALL go directly to the burst state.
REQ-016 Each burst SHALL move one c_WORD_SIZE word per cycle for c_WORDS_PER_LINE cycles; word k is line bits [k*c_WORD_SIZE +: c_WORD_SIZE], k=0 first.
REQ-017 Word address inside the backing store SHALL be {latched line address, k}; k SHALL wrap to 0 after c_WORDS_PER_LINE-1, and the burst SHALL end.
REQ-018 READ_BURST SHALL assemble words into a line buffer; MI_OUT_DATA SHALL load the completed buffer on entry to ACK and otherwise hold its value.
REQ-019 MI_SIG_RAM_ACK SHALL be high for exactly one cycle, ACCESS_LATENCY+c_WORDS_PER_LINE+1 rising edges after the accepting edge (9 with defaults).
REQ-020 After ACK, the FSM SHALL stay in WAIT_RELEASE until SIG_RAM_RD=0 and SIG_RAM_WR=0 are sampled, then go to IDLE; a held level SHALL never start a second transaction.
REQ-021 Request, address and data changes after acceptance SHALL be ignored until IDLE.
REQ-022 A write followed by a read of the same line SHALL return the written line exactly.

Reset
REQ-023 RESET SHALL force state IDLE, MI_SIG_RAM_ACK=0, BUSY=0, MI_OUT_DATA=0, and clear the counters and line buffer, with priority over all other inputs.
REQ-024 RESET during a burst SHALL abort it with no ACK; words already written SHALL remain, and backing store contents SHALL not otherwise be changed by reset.

Structure
REQ-025 c_WORD_SIZE (32) and c_WORDS_PER_LINE (c_RAM_DATA_SIZE/c_WORD_SIZE) SHALL be added to the shared Constants.vh, alongside existing sizes; state encodings SHALL stay local.
REQ-026 The backing store SHALL be one sub-module, ram_word_array: single-port, combinational read, synchronous write, depth 2**MEM_DEPTH_LOG2 * c_WORDS_PER_LINE.

Verification
REQ-027 Reset, then write line 0x0123..CDEF to address 0x05 (defaults) -> ACK on the 9th edge, BUSY high on edges 1-8, array words 0x14..0x17 hold the line slices.
REQ-028 Read address 0x05 after REQ-027 -> MI_OUT_DATA equals the written line on the ACK cycle; ACK is high for one cycle only.
REQ-029 Hold SIG_RAM_RD high for 20 cycles after ACK -> no second ACK; dropping it for one cycle then raising it -> new transaction with ACK 9 edges later.
REQ-030 Assert RD and WR together with MI_IN_DATA=all ones, address 0x07 -> write performed; a subsequent read returns all ones.
REQ-031 With ACCESS_LATENCY=0, a read -> ACK on the 5th edge after acceptance.
REQ-032 Assert RESET at burst word 2 of a write to address 0x09 -> no ACK, FSM in IDLE, MI_OUT_DATA=0, words 0 and 1 updated, words 2 and 3 unchanged.

Source files
------------

// File: rtl/memory_interface_pkg.sv
// Shared sizes for the cache/memory path and the helper types used by the
// line-burst memory interface.
package memory_interface_pkg;

  localparam int unsigned c_ADDR_TAG_SIZE   = 4;
  localparam int unsigned c_ADDR_INDEX_SIZE = 4;
  localparam int unsigned c_RAM_DATA_SIZE   = 128;
  localparam int unsigned c_WORD_SIZE       = 32;
  localparam int unsigned c_WORDS_PER_LINE  = c_RAM_DATA_SIZE / c_WORD_SIZE;
  localparam int unsigned c_WORD_SEL_SIZE   = $clog2(c_WORDS_PER_LINE);

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/memory_interface_ram.sv
// Word-organised backing store: single port, combinational read, write on
// the rising clock edge.
module ram_word_array
  import memory_interface_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = c_WORD_SIZE
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_interface.sv
// Line-granular memory interface: accepts a cache read or write-back request,
// waits a fixed latency, then bursts the line one word per cycle.
module memory_interface
  import memory_interface_pkg::*;
#(
  parameter int unsigned ACCESS_LATENCY = 4,
  parameter int unsigned MEM_DEPTH_LOG2 = c_ADDR_TAG_SIZE + c_ADDR_INDEX_SIZE
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       SIG_RAM_RD,
  input  logic                       SIG_RAM_WR,
  input  logic [MEM_DEPTH_LOG2-1:0]  RAM_ADDR,
  input  logic [c_RAM_DATA_SIZE-1:0] MI_IN_DATA,
  output logic [c_RAM_DATA_SIZE-1:0] MI_OUT_DATA,
  output logic                       MI_SIG_RAM_ACK,
  output logic                       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATENCY,
    S_READ_BURST,
    S_WRITE_BURST,
    S_ACK,
    S_WAIT_RELEASE
  } state_t;

  localparam logic [3:0]                 LAT       = 4'(ACCESS_LATENCY);
  localparam logic [c_WORD_SEL_SIZE-1:0] LAST_WORD = c_WORD_SEL_SIZE'(c_WORDS_PER_LINE - 1);

  state_t                       state, next_state;
  op_t                          op;
  logic [3:0]                   lat_cnt;
  logic [c_WORD_SEL_SIZE-1:0]   word_idx;
  logic [MEM_DEPTH_LOG2-1:0]    line_addr;
  logic [c_RAM_DATA_SIZE-1:0]   line_data;
  logic [c_RAM_DATA_SIZE-1:0]   line_buf;
  logic [c_RAM_DATA_SIZE-1:0]   buf_next;
  logic                         last;
  logic                         store_we;
  logic [c_WORD_SIZE-1:0]       store_wdata;
  logic [c_WORD_SIZE-1:0]       store_rdata;

  assign last        = (word_idx == LAST_WORD);
  assign BUSY        = (state != S_IDLE);
  assign store_wdata = line_data[word_idx*c_WORD_SIZE +: c_WORD_SIZE];
  // Gated by RESET so the edge that aborts a write burst does not land its word.
  assign store_we    = (state == S_WRITE_BURST) && !RESET;

  ram_word_array #(
    .ADDR_W(MEM_DEPTH_LOG2 + c_WORD_SEL_SIZE),
    .DATA_W(c_WORD_SIZE)
  ) u_store (
    .clk  (CLK),
    .we   (store_we),
    .addr ({line_addr, word_idx}),
    .wdata(store_wdata),
    .rdata(store_rdata)
  );

  always_comb begin
    buf_next = line_buf;
    buf_next[word_idx*c_WORD_SIZE +: c_WORD_SIZE] = store_rdata;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (SIG_RAM_WR || SIG_RAM_RD) begin
          if (ACCESS_LATENCY == 0) next_state = SIG_RAM_WR ? S_WRITE_BURST : S_READ_BURST;
          else                     next_state = S_LATENCY;
        end
      end
      S_LATENCY: begin
        if (lat_cnt == 4'd1) next_state = (op == OP_WRITE) ? S_WRITE_BURST : S_READ_BURST;
      end
      S_READ_BURST, S_WRITE_BURST: begin
        if (last) next_state = S_ACK;
      end
      S_ACK:          next_state = S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        if (!SIG_RAM_RD && !SIG_RAM_WR) next_state = S_IDLE;
      end
      default:        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      op             <= OP_READ;
      lat_cnt        <= '0;
      word_idx       <= '0;
      line_addr      <= '0;
      line_data      <= '0;
      line_buf       <= '0;
      MI_OUT_DATA    <= '0;
      MI_SIG_RAM_ACK <= 1'b0;
    end else begin
      state          <= next_state;
      // The pulse is registered from the ACK state, landing one edge after it.
      MI_SIG_RAM_ACK <= (state == S_ACK);
      case (state)
        S_IDLE: begin
          if (SIG_RAM_WR || SIG_RAM_RD) begin
            line_addr <= RAM_ADDR;
            lat_cnt   <= LAT;
            word_idx  <= '0;
            op        <= SIG_RAM_WR ? OP_WRITE : OP_READ;
            if (SIG_RAM_WR) line_data <= MI_IN_DATA;
          end
        end
        S_LATENCY: lat_cnt <= lat_cnt - 4'd1;
        S_READ_BURST: begin
          line_buf <= buf_next;
          word_idx <= last ? '0 : word_idx + 1'b1;
          if (last) MI_OUT_DATA <= buf_next;
        end
        S_WRITE_BURST: word_idx <= last ? '0 : word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: directed vectors, reset/hold corner cases and
// random traffic against a line-level memory model.
module tb_memory_interface;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd, wr, rd0, wr0;
  logic [7:0]   addr, addr0;
  logic [127:0] din, din0, dout, dout0;
  logic         ack, busy, ack0, busy0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] model [logic [7:0]];
  logic [127:0] last_out;

  always #5 clk = ~clk;

  memory_interface dut (
    .CLK(clk), .RESET(rst), .SIG_RAM_RD(rd), .SIG_RAM_WR(wr), .RAM_ADDR(addr),
    .MI_IN_DATA(din), .MI_OUT_DATA(dout), .MI_SIG_RAM_ACK(ack), .BUSY(busy)
  );

  memory_interface #(.ACCESS_LATENCY(0)) dut0 (
    .CLK(clk), .RESET(rst), .SIG_RAM_RD(rd0), .SIG_RAM_WR(wr0), .RAM_ADDR(addr0),
    .MI_IN_DATA(din0), .MI_OUT_DATA(dout0), .MI_SIG_RAM_ACK(ack0), .BUSY(busy0)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called with the request already accepted; counts edges to the ACK pulse.
  task automatic wait_ack(input int exp_lat, output logic [127:0] got);
    int ack_at = -1;
    got = '0;
    for (int e = 1; e <= 20 && ack_at < 0; e++) begin
      @(posedge clk); #1;
      if (ack) begin
        ack_at = e;
        got = dout;
      end else if (e < exp_lat) begin
        check("busy_during", 128'(busy), 128'(1'b1));
      end
    end
    check("ack_latency", 128'(ack_at), 128'(exp_lat));
  endtask

  task automatic txn(input logic t_rd, input logic t_wr, input logic [7:0] t_addr,
                     input logic [127:0] t_data, output logic [127:0] got);
    rd = t_rd; wr = t_wr; addr = t_addr; din = t_data;
    @(posedge clk); #1;
    addr = 8'($urandom);
    din  = rand_line();
    wait_ack(9, got);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 128'(ack), 128'(1'b0));
    check("busy_released", 128'(busy), 128'(1'b0));
  endtask

  task automatic txn0(input logic t_rd, input logic t_wr, input logic [7:0] t_addr,
                      input logic [127:0] t_data, output logic [127:0] got);
    int ack_at = -1;
    got = '0;
    rd0 = t_rd; wr0 = t_wr; addr0 = t_addr; din0 = t_data;
    @(posedge clk); #1;
    for (int e = 1; e <= 20 && ack_at < 0; e++) begin
      @(posedge clk); #1;
      if (ack0) begin
        ack_at = e;
        got = dout0;
      end
    end
    check("lat0_ack_latency", 128'(ack_at), 128'(5));
    rd0 = 1'b0; wr0 = 1'b0;
    @(posedge clk); #1;
    check("lat0_ack_one_cycle", 128'(ack0), 128'(1'b0));
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [7:0]   addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  initial begin
    vec_t         vecs [6];
    logic [127:0] line_a, line_b, line_c, ones, merged, got;
    logic [7:0]   a;
    int           kind;

    line_a = 128'h01234567_76543210_FEDCBA98_89ABCDEF;
    line_b = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
    line_c = 128'hC0DEC0DE_BEEFBEEF_0BADF00D_600DCAFE;
    ones   = '1;
    vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 8'h05, data: line_a, exp: '0};
    vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 8'h05, data: line_c, exp: line_a};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 8'h07, data: ones,   exp: '0};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 8'h07, data: '0,     exp: ones};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 8'h09, data: line_b, exp: '0};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 8'h09, data: '0,     exp: line_b};

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 128'(ack), 128'(1'b0));
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_dout", dout, '0);
    rst = 1'b0;
    last_out = '0;

    // Directed vectors; a write must leave MI_OUT_DATA holding the last read line.
    foreach (vecs[i]) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, got);
      if (vecs[i].wr) begin
        model[vecs[i].addr] = vecs[i].data;
        check("vec_write_hold", got, last_out);
      end else begin
        check("vec_read_data", got, vecs[i].exp);
        last_out = vecs[i].exp;
      end
    end

    for (int k = 0; k < 4; k++)
      check("array_word", 128'(dut.u_store.mem[8'h14 + k]), 128'(line_a[k*32 +: 32]));

    // A held read level must not restart; one low cycle then a new request.
    rd = 1'b1; addr = 8'h05;
    @(posedge clk); #1;
    wait_ack(9, got);
    check("hold_read_data", got, line_a);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("hold_no_ack", 128'(ack), 128'(1'b0));
    end
    check("hold_busy", 128'(busy), 128'(1'b1));
    rd = 1'b0;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 8'h05, '0, got);
    check("rerequest_data", got, line_a);

    // Reset while word 2 of a write burst to 0x09 is on the bus.
    wr = 1'b1; addr = 8'h09; din = line_c;
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ack", 128'(ack), 128'(1'b0));
    check("abort_busy", 128'(busy), 128'(1'b0));
    check("abort_dout", dout, '0);
    rst = 1'b0; wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("abort_no_ack", 128'(ack), 128'(1'b0));
    end
    merged = {line_b[127:64], line_c[63:0]};
    model[8'h09] = merged;
    for (int k = 0; k < 4; k++)
      check("abort_word", 128'(dut.u_store.mem[8'h24 + k]), 128'(merged[k*32 +: 32]));
    txn(1'b1, 1'b0, 8'h09, '0, got);
    check("abort_readback", got, merged);
    last_out = merged;

    // Random traffic over a small pool of lines.
    for (int k = 0; k < 8; k++) begin
      a = 8'h30 + 8'(k);
      model[a] = rand_line();
      txn(1'b0, 1'b1, a, model[a], got);
      check("rand_init_hold", got, last_out);
    end
    for (int t = 0; t < 25; t++) begin
      a    = 8'h30 + 8'($urandom_range(0, 7));
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        txn(1'b1, 1'b0, a, rand_line(), got);
        check("rand_read", got, model[a]);
        last_out = model[a];
      end else begin
        din = rand_line();
        model[a] = din;
        txn(kind == 2, 1'b1, a, model[a], got);
        check("rand_write_hold", got, last_out);
      end
    end

    // Zero-latency instance: write then read the same line.
    txn0(1'b0, 1'b1, 8'h11, line_c, got);
    txn0(1'b1, 1'b0, 8'h11, '0, got);
    check("lat0_read_data", got, line_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
